fetch: RTL and testbench

Instruction fetch stage of the Qu pipeline and the producer side of the decode stage's `instr_in`/`pc_in` interface. Keeps the program counter, issues sequential word requests to instruction memory over an in-order request/grant/response bus, and buffers returned instructions with their PCs in a small FIFO. Decode draws entries with a valid/ready handshake. A redirect from branch/jump resolution flushes the buffer, discards in-flight responses and restarts at the new target.

---
 rtl/fetch.sv | 134 +++++++++++++
 tb/tb_fetch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Qu instruction fetch: PC sequencing, credit-limited imem requests, response FIFO toward decode.
// Optional QU_FETCH_MISALIGN_CHECK_EN: misaligned redirect raises a sticky fault that blocks fetch.
module fetch #(
  parameter int          INSTR_WIDTH = 32,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [31:0]            out_pc,
  input  logic                   out_ready,
  output logic                   misaligned
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  typedef logic [31:0] pc_t;
  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    pc_t                    pc;
  } entry_t;

  pc_t           fetch_pc_q, fetch_pc_d;
  pc_t           resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  entry_t        buf_q [FIFO_DEPTH];

  pc_t  tgt;
  logic fault;
  logic credit, grant, resp, keep, pop;

`ifdef QU_FETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign tgt   = redirect_pc;
  assign fault = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (redirect) fault_d = |redirect_pc[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
`else
  assign tgt   = redirect_pc & 32'hFFFF_FFFC;
  assign fault = 1'b0;
`endif

  // Outstanding requests and buffered entries share the FIFO's capacity.
  assign credit    = ({1'b0, outst_q} + {1'b0, count_q}) < DEPTH_W;
  assign imem_req  = !rst && !redirect && !fault && credit;
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (outst_q != '0);
  assign keep      = resp && (drop_q == '0) && !redirect;
  assign pop       = out_valid && out_ready && !redirect;

  assign out_valid  = (count_q != '0);
  assign out_instr  = out_valid ? buf_q[rptr_q].instr : '0;
  assign out_pc     = out_valid ? buf_q[rptr_q].pc    : '0;
  assign misaligned = fault;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    if (redirect) begin
      // Everything still in flight belongs to the old stream; pending drops
      // are already part of outstanding, so the drop count is just what remains.
      fetch_pc_d = tgt;
      resp_pc_d  = tgt;
      outst_d    = outst_q - CW'(resp);
      drop_d     = outst_q - CW'(resp);
      count_d    = '0;
      wptr_d     = '0;
      rptr_d     = '0;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
      outst_d = outst_q + CW'(grant) - CW'(resp);
      if (resp) begin
        if (drop_q != '0) drop_d    = drop_q - 1'b1;
        else              resp_pc_d = resp_pc_q + 32'd4;
      end
      if (keep) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      count_d = count_q + CW'(keep) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      count_q    <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (keep) buf_q[wptr_q] <= '{instr: imem_rdata, pc: resp_pc_q};
  end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: in-order memory model plus queue-based scoreboard of the expected stream.
module tb_fetch;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          DEPTH  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid, out_ready, misaligned;
  logic [31:0] out_instr, out_pc;

  fetch #(.INSTR_WIDTH(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_ready(out_ready), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int cyc, lat, last_due, n_pop;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  bit          mq_live[$];
  logic [31:0] fq[$];
  logic [31:0] granted[$];
  logic [31:0] popped_pcs[$];
  logic [31:0] exp_addr;
  bit          fault_m;
  logic        last_req, last_valid, last_mis;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic clear_model;
    mq_addr.delete(); mq_due.delete(); mq_live.delete(); fq.delete();
    granted.delete(); popped_pcs.delete();
    exp_addr = RST_PC; fault_m = 1'b0; cyc = 0; last_due = 0;
  endtask

  task automatic idle_inputs;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
    redirect = 0; redirect_pc = '0; out_ready = 0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    clear_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One clock: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit gnt, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input bit spur);
    bit resp, live, ex_req, popped;
    logic [31:0] raddr;
    int due;
    @(negedge clk);
    imem_gnt = gnt; out_ready = rdy; redirect = redir; redirect_pc = rpc;
    resp = (mq_addr.size() != 0) && (mq_due[0] <= cyc);
    imem_rvalid = resp | spur;
    imem_rdata  = resp ? mem_word(mq_addr[0]) : (spur ? 32'hDEAD_BEEF : 32'h0);
    #1;
    last_req = imem_req; last_addr = imem_addr; last_valid = out_valid; last_mis = misaligned;
    ex_req = !redir && !fault_m && ((mq_addr.size() + fq.size()) < DEPTH);
    n_chk++;
    if (imem_req !== ex_req) $display("FAIL imem_req cyc %0d: got %b want %b", cyc, imem_req, ex_req);
    else n_pass++;
    if (ex_req) begin
      n_chk++;
      if (imem_addr !== exp_addr) $display("FAIL imem_addr cyc %0d: got %h want %h", cyc, imem_addr, exp_addr);
      else n_pass++;
    end
    n_chk++;
    if (out_valid !== (fq.size() != 0)) $display("FAIL out_valid cyc %0d: got %b want %b", cyc, out_valid, fq.size() != 0);
    else n_pass++;
    n_chk++;
    if (fq.size() != 0) begin
      if (out_pc !== fq[0] || out_instr !== mem_word(fq[0]))
        $display("FAIL out_entry cyc %0d: got pc %h instr %h want pc %h instr %h", cyc, out_pc, out_instr, fq[0], mem_word(fq[0]));
      else n_pass++;
    end else begin
      if (out_pc !== 32'h0 || out_instr !== 32'h0)
        $display("FAIL out_idle cyc %0d: got pc %h instr %h want 0", cyc, out_pc, out_instr);
      else n_pass++;
    end
    n_chk++;
    if (misaligned !== fault_m) $display("FAIL misaligned cyc %0d: got %b want %b", cyc, misaligned, fault_m);
    else n_pass++;

    popped = rdy && (fq.size() != 0) && !redir;
    live = 1'b0; raddr = '0;
    if (resp) begin
      raddr = mq_addr.pop_front();
      live  = mq_live.pop_front();
      void'(mq_due.pop_front());
    end
    if (redir) begin
      fq.delete();
      foreach (mq_live[i]) mq_live[i] = 1'b0;
`ifdef QU_FETCH_MISALIGN_CHECK_EN
      exp_addr = rpc;
      fault_m  = (rpc[1:0] != 2'b00);
`else
      exp_addr = {rpc[31:2], 2'b00};
`endif
    end else begin
      if (popped) begin popped_pcs.push_back(fq.pop_front()); n_pop++; end
      if (resp && live) fq.push_back(raddr);
      if (ex_req && gnt) begin
        due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        granted.push_back(exp_addr);
        mq_addr.push_back(exp_addr); mq_live.push_back(1'b1); mq_due.push_back(due);
        last_due = due;
        exp_addr = exp_addr + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b want 0", imem_req); else n_pass++;
    n_chk++; if (imem_addr !== RST_PC) $display("FAIL rst_addr: got %h want %h", imem_addr, RST_PC); else n_pass++;
    n_chk++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== 32'h0)
      $display("FAIL rst_out: got v %b pc %h instr %h want 0", out_valid, out_pc, out_instr); else n_pass++;
    n_chk++; if (misaligned !== 1'b0) $display("FAIL rst_mis: got %b want 0", misaligned); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++; if (imem_req !== 1'b1 || imem_addr !== RST_PC)
      $display("FAIL first_req: got %b @%h want 1 @%h", imem_req, imem_addr, RST_PC); else n_pass++;
  endtask

  task automatic test_stream;
    int p0;
    do_reset(); lat = 1;
    repeat (8) step(1, 1, 0, '0, 0);
    p0 = n_pop;
    repeat (16) step(1, 1, 0, '0, 0);
    n_chk++; if (n_pop - p0 != 16) $display("FAIL throughput: got %0d pops want 16", n_pop - p0); else n_pass++;
    n_chk++; if (popped_pcs[0] !== 32'h0 || popped_pcs[1] !== 32'h4 || popped_pcs[2] !== 32'h8)
      $display("FAIL stream_pcs: got %h %h %h want 0 4 8", popped_pcs[0], popped_pcs[1], popped_pcs[2]); else n_pass++;
  endtask

  task automatic test_backpressure;
    do_reset(); lat = 1;
    repeat (10) step(1, 0, 0, '0, 0);
    n_chk++; if (granted.size() != DEPTH) $display("FAIL bp_grants: got %0d want %0d", granted.size(), DEPTH); else n_pass++;
    n_chk++; if (last_req !== 1'b0) $display("FAIL bp_req_low: got %b want 0", last_req); else n_pass++;
    repeat (6) step(0, 1, 0, '0, 0);
    n_chk++;
    if (popped_pcs.size() != 4 || popped_pcs[0] !== 32'h0 || popped_pcs[1] !== 32'h4 ||
        popped_pcs[2] !== 32'h8 || popped_pcs[3] !== 32'hC)
      $display("FAIL bp_order: got %0d entries first %h want 0,4,8,c", popped_pcs.size(), popped_pcs[0]);
    else n_pass++;
  endtask

  task automatic test_redirect_inflight;
    do_reset(); lat = 3;
    repeat (2) step(1, 1, 0, '0, 0);
    step(1, 1, 1, 32'h100, 0);
    repeat (12) step(1, 1, 0, '0, 0);
    n_chk++; if (popped_pcs[0] !== 32'h100) $display("FAIL inflight_drop: got first pc %h want 100", popped_pcs[0]); else n_pass++;
    n_chk++; if (granted[2] !== 32'h100) $display("FAIL inflight_req: got %h want 100", granted[2]); else n_pass++;
  endtask

  task automatic test_redirect_coincident;
    do_reset(); lat = 1;
    repeat (5) step(1, 1, 0, '0, 0);
    step(1, 1, 1, 32'h100, 0);
    step(1, 1, 0, '0, 0);
    n_chk++; if (last_valid !== 1'b0) $display("FAIL coinc_valid: got %b want 0", last_valid); else n_pass++;
    n_chk++; if (last_req !== 1'b1 || last_addr !== 32'h100)
      $display("FAIL coinc_req: got %b @%h want 1 @100", last_req, last_addr); else n_pass++;
    repeat (4) step(1, 1, 0, '0, 0);
  endtask

  task automatic test_wrap;
    do_reset(); lat = 1;
    step(1, 1, 1, 32'hFFFF_FFF8, 0);
    repeat (8) step(1, 1, 0, '0, 0);
    n_chk++; if (granted[0] !== 32'hFFFF_FFF8 || granted[1] !== 32'hFFFF_FFFC || granted[2] !== 32'h0)
      $display("FAIL wrap_addr: got %h %h %h want fffffff8 fffffffc 0", granted[0], granted[1], granted[2]); else n_pass++;
    n_chk++; if (popped_pcs[2] !== 32'h0) $display("FAIL wrap_pc: got %h want 0", popped_pcs[2]); else n_pass++;
  endtask

  task automatic test_misalign;
    do_reset(); lat = 1;
    step(1, 1, 1, 32'h102, 0);
    step(1, 1, 0, '0, 0);
`ifdef QU_FETCH_MISALIGN_CHECK_EN
    n_chk++; if (last_mis !== 1'b1 || last_req !== 1'b0)
      $display("FAIL mis_set: got mis %b req %b want 1 0", last_mis, last_req); else n_pass++;
    repeat (3) step(1, 1, 0, '0, 0);
    step(1, 1, 1, 32'h200, 0);
    repeat (5) step(1, 1, 0, '0, 0);
    n_chk++; if (last_mis !== 1'b0 || granted[0] !== 32'h200)
      $display("FAIL mis_clear: got mis %b first %h want 0 200", last_mis, granted[0]); else n_pass++;
`else
    n_chk++; if (last_mis !== 1'b0 || last_req !== 1'b1 || last_addr !== 32'h100)
      $display("FAIL mis_force: got mis %b req %b @%h want 0 1 @100", last_mis, last_req, last_addr); else n_pass++;
    repeat (4) step(1, 1, 0, '0, 0);
`endif
  endtask

  task automatic test_reset_midop;
    do_reset(); lat = 3;
    repeat (6) step(1, 0, 0, '0, 0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    n_chk++; if (out_valid !== 1'b0 || imem_req !== 1'b0)
      $display("FAIL async_rst: got v %b req %b want 0 0", out_valid, imem_req); else n_pass++;
    do_reset();
    step(0, 1, 0, '0, 1);
    step(0, 1, 0, '0, 0);
    n_chk++; if (last_valid !== 1'b0) $display("FAIL spurious: got v %b want 0", last_valid); else n_pass++;
    repeat (6) step(1, 1, 0, '0, 0);
  endtask

  task automatic test_random;
    int p0;
    logic [31:0] rpc;
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      lat = $urandom_range(1, 4);
      for (int k = 0; k < 300; k++) begin
        rpc = $urandom & 32'hFFFF_FFFC;
        if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0;
        step($urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60,
             $urandom_range(0, 99) < 4, rpc, 0);
      end
    end
    p0 = n_pop;
    repeat (20) step(1, 1, 0, '0, 0);
    n_chk++; if (n_pop - p0 < 10) $display("FAIL rand_drain: got %0d pops want >=10", n_pop - p0); else n_pass++;
  endtask

  initial begin
    n_pop = 0; lat = 1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_coincident();
    test_wrap();
    test_misalign();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
